// File: rtl/rst_seq_ctrl.sv
// Power-up / recovery reset sequencer: releases SDRAM, camera-config and VGA resets
// in order, waits on each done handshake with a timeout, retries, then parks in ERR.
module rst_seq_ctrl #(
    parameter int unsigned DLY_PWR   = 10000,
    parameter int unsigned TIMEOUT   = 2000000,
    parameter int unsigned DLY_VGA   = 1000,
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned CNT_W     = 32
) (
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic       soft_rst_req,
    input  logic       sdram_init_done,
    input  logic       cam_cfg_done,
    output logic       rst_sdram_n,
    output logic       rst_cam_n,
    output logic       rst_vga_n,
    output logic [2:0] seq_state,
    output logic       seq_done,
    output logic       seq_err,
    output logic [1:0] retry_cnt
);

    typedef enum logic [2:0] {
        WAIT_PWR  = 3'd0,
        REL_SDRAM = 3'd1,
        REL_CAM   = 3'd2,
        REL_VGA   = 3'd3,
        RUN       = 3'd4,
        ERR       = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(DLY_PWR - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] VGA_LAST = CNT_W'(DLY_VGA - 1);
    localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRY);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       retry_cnt_reg, retry_cnt_next;
    logic             fail;

    logic rst_sdram_n_reg, rst_cam_n_reg, rst_vga_n_reg;
    logic seq_done_reg, seq_err_reg;

    always_comb begin
        state_next     = state_reg;
        retry_cnt_next = retry_cnt_reg;
        fail           = 1'b0;

        case (state_reg)
            WAIT_PWR: begin
                if (cnt_reg == PWR_LAST) state_next = REL_SDRAM;
            end
            REL_SDRAM: begin
                // done wins over a simultaneous timeout
                if (sdram_init_done)        state_next = REL_CAM;
                else if (cnt_reg == TO_LAST) fail = 1'b1;
            end
            REL_CAM: begin
                if (cam_cfg_done)           state_next = REL_VGA;
                else if (cnt_reg == TO_LAST) fail = 1'b1;
            end
            REL_VGA: begin
                if (cnt_reg == VGA_LAST) state_next = RUN;
            end
            RUN: begin
                if (!sdram_init_done || !cam_cfg_done) fail = 1'b1;
            end
            ERR:     state_next = ERR;
            default: state_next = WAIT_PWR;
        endcase

        if (fail) begin
            if (retry_cnt_reg < RETRY_LIMIT) begin
                retry_cnt_next = retry_cnt_reg + 2'd1;
                state_next     = WAIT_PWR;
            end else begin
                state_next = ERR;
            end
        end

        if (soft_rst_req) begin
            state_next     = WAIT_PWR;
            retry_cnt_next = 2'd0;
        end

        // RUN and ERR dwell indefinitely, so the counter saturates rather than wraps
        if (soft_rst_req || (state_next != state_reg))
            cnt_next = '0;
        else if (cnt_reg != {CNT_W{1'b1}})
            cnt_next = cnt_reg + 1'b1;
        else
            cnt_next = cnt_reg;
    end

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            state_reg       <= WAIT_PWR;
            cnt_reg         <= '0;
            retry_cnt_reg   <= 2'd0;
            rst_sdram_n_reg <= 1'b0;
            rst_cam_n_reg   <= 1'b0;
            rst_vga_n_reg   <= 1'b0;
            seq_done_reg    <= 1'b0;
            seq_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            retry_cnt_reg   <= retry_cnt_next;
            // outputs decoded from the next state so they change on the transition edge
            rst_sdram_n_reg <= (state_next == REL_SDRAM) || (state_next == REL_CAM) ||
                               (state_next == REL_VGA)   || (state_next == RUN);
            rst_cam_n_reg   <= (state_next == REL_CAM) || (state_next == REL_VGA) ||
                               (state_next == RUN);
            rst_vga_n_reg   <= (state_next == RUN);
            seq_done_reg    <= (state_next == RUN);
            seq_err_reg     <= (state_next == ERR);
        end
    end

    assign rst_sdram_n = rst_sdram_n_reg;
    assign rst_cam_n   = rst_cam_n_reg;
    assign rst_vga_n   = rst_vga_n_reg;
    assign seq_state   = state_reg;
    assign seq_done    = seq_done_reg;
    assign seq_err     = seq_err_reg;
    assign retry_cnt   = retry_cnt_reg;

endmodule
